// File: rtl/boost_duty_ctrl.sv
// Boost PWM duty sequencer: clamps requested duty, soft-ramps the applied
// duty one STEP per control interrupt, handles shutdown ramp and latched fault.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | output off, waiting for enable
// RAMP     | stepping d_boost toward the target on each tick
// HOLD     | d_boost equals target, waiting for a new target
// SHUTDOWN | stepping d_boost down to zero on each tick
// FAULT    | duty forced to zero, target cleared, waiting for release
module boost_duty_ctrl #(
    parameter int unsigned D_MAX = 900,
    parameter int unsigned STEP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       enable,
    input  logic       fault,
    input  logic       clk_int,
    input  logic [9:0] tgt_duty,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    output logic [9:0] d_boost,
    output logic       at_target,
    output logic       fault_latched,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_HOLD     = 3'd2,
        ST_SHUTDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [9:0]  STEP_10 = 10'(STEP);
    localparam logic [9:0]  D_MAX_W = 10'(D_MAX);

    state_t     state_q, state_d;
    logic [9:0] duty_q, duty_d;
    logic [9:0] tgt_q, tgt_d;
    logic       at_target_q, at_target_d;
    logic       fault_latched_q, fault_latched_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       sync3_q, sync3_d;

    logic        tick;
    logic        xfer;
    logic [9:0]  tgt_clamped;
    logic [10:0] duty_ext;
    logic [10:0] tgt_ext;
    logic [10:0] up_sum;
    logic [9:0]  ramp_up;
    logic [9:0]  ramp_dn;
    logic [9:0]  ramp_step;
    logic [9:0]  ramp_next;
    logic [9:0]  sd_floor;
    logic [9:0]  sd_next;

    // clk_int arrives from the slow domain; sync2 vs sync3 gives one pulse per rising edge
    assign tick = sync2_q & ~sync3_q;

    assign tgt_ready   = (state_q != ST_FAULT);
    assign xfer        = tgt_valid & tgt_ready & ce;
    assign tgt_clamped = (tgt_duty > D_MAX_W) ? D_MAX_W : tgt_duty;

    // Step arithmetic is done one bit wider so neither direction can wrap
    assign duty_ext = {1'b0, duty_q};
    assign tgt_ext  = {1'b0, tgt_q};
    assign up_sum   = duty_ext + STEP_W;
    assign ramp_up  = (up_sum >= tgt_ext) ? tgt_q : up_sum[9:0];
    assign ramp_dn  = (duty_ext >= (tgt_ext + STEP_W)) ? (duty_q - STEP_10) : tgt_q;

    assign ramp_step = (duty_q < tgt_q) ? ramp_up :
                       (duty_q > tgt_q) ? ramp_dn : duty_q;
    assign ramp_next = tick ? ramp_step : duty_q;

    assign sd_floor = (duty_ext > STEP_W) ? (duty_q - STEP_10) : 10'd0;
    assign sd_next  = tick ? sd_floor : duty_q;

    // Next-state, duty, target and flag computation; everything holds while ce is low
    always_comb begin
        state_d         = state_q;
        duty_d          = duty_q;
        tgt_d           = tgt_q;
        at_target_d     = at_target_q;
        fault_latched_d = fault_latched_q;
        sync1_d         = sync1_q;
        sync2_d         = sync2_q;
        sync3_d         = sync3_q;

        if (ce) begin
            sync1_d = clk_int;
            sync2_d = sync1_q;
            sync3_d = sync2_q;

            if (xfer) begin
                tgt_d = tgt_clamped;
            end

            if (fault) begin
                state_d = ST_FAULT;
                duty_d  = 10'd0;
                tgt_d   = 10'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        duty_d = 10'd0;
                        if (enable) begin
                            state_d = ST_RAMP;
                        end
                    end
                    ST_RAMP: begin
                        if (!enable) begin
                            state_d = ST_SHUTDOWN;
                        end else begin
                            // step follows the old target; HOLD only once duty matches the live one
                            duty_d = ramp_next;
                            if (ramp_next == tgt_d) begin
                                state_d = ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!enable) begin
                            state_d = ST_SHUTDOWN;
                        end else if (xfer && (tgt_clamped != duty_q)) begin
                            state_d = ST_RAMP;
                        end
                    end
                    ST_SHUTDOWN: begin
                        if (enable) begin
                            state_d = ST_RAMP;
                        end else begin
                            duty_d = sd_next;
                            if (sd_next == 10'd0) begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    ST_FAULT: begin
                        duty_d = 10'd0;
                        if (!enable) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        duty_d  = 10'd0;
                    end
                endcase
            end

            at_target_d     = (state_d == ST_HOLD) && (duty_d == tgt_d);
            fault_latched_d = (state_d == ST_FAULT);
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            duty_q          <= 10'd0;
            tgt_q           <= 10'd0;
            at_target_q     <= 1'b0;
            fault_latched_q <= 1'b0;
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            sync3_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            duty_q          <= duty_d;
            tgt_q           <= tgt_d;
            at_target_q     <= at_target_d;
            fault_latched_q <= fault_latched_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            sync3_q         <= sync3_d;
        end
    end

    assign d_boost       = duty_q;
    assign at_target     = at_target_q;
    assign fault_latched = fault_latched_q;
    assign state         = state_q;

endmodule

// File: doc/boost_duty_ctrl.md
# boost_duty_ctrl

Soft-start and duty-cycle sequencer for the boost PWM stage. Accepts a requested duty from the control loop, clamps it, and moves the applied duty toward it in fixed steps, one step per control interrupt (the 60 µs `clk_int` tick from the boost block). Drives the boost block's 10-bit duty input. Handles enable/shutdown ramps and a latched fault that forces duty to zero.

## Interface
- `D_MAX`, 900: upper clamp on accepted target duty (counts, 10-bit)
- `STEP`, 4: duty change applied per tick while ramping (1..255)
- `clk`  in  1: system clock (100 MHz)
- `rst`  in  1: synchronous, active-high reset
- `ce`  in  1: clock enable; when low, all registers hold (handshake outputs still combinationally valid)
- `enable`  in  1: run request; level-sensitive
- `fault`  in  1: fault input; level-sensitive; highest priority after `rst`
- `clk_int`  in  1: control interrupt from boost block (slow-clock domain, asynchronous to `clk`)
- `tgt_duty`  in  10: requested duty
- `tgt_valid`  in  1: `tgt_duty` valid
- `tgt_ready`  out  1: target can be accepted this cycle
- `d_boost`  out  10: applied duty to boost block
- `at_target`  out  1: `d_boost` equals the clamped target and state is HOLD
- `fault_latched`  out  1: state is FAULT
- `state`  out  3: IDLE=0, RAMP=1, HOLD=2, SHUTDOWN=3, FAULT=4

## Operation
- Reset values: `d_boost`=0, target register=0, state=IDLE, `at_target`=0, `fault_latched`=0, synchronizer/edge registers=0.
- Tick: `clk_int` passes through a 2-flop synchronizer, then a rising-edge detector; `tick` is a one-cycle pulse. Each `clk_int` rising edge yields exactly one `tick`.
- Handshake: `tgt_ready` = (state != FAULT). Transfer occurs when `tgt_valid & tgt_ready & ce`. Captured target = min(`tgt_duty`, `D_MAX`). Back-to-back transfers allowed; the last one wins.
- IDLE: `d_boost`=0. `enable`=1 -> RAMP.
- RAMP: on `tick`, if `d_boost` < target, then `d_boost` = min(`d_boost`+STEP, target); if `d_boost` > target, then `d_boost` = max(`d_boost`−STEP, target). Compute in 11 bits, so there is no wrap at 0 or 1023. When the updated value equals the target, go to HOLD. If `d_boost` already equals the target, go to HOLD on the next `ce` cycle without waiting for a tick. `enable`=0 -> SHUTDOWN.
- HOLD: `d_boost` is unchanged. An accepted target different from `d_boost` -> RAMP. `enable`=0 -> SHUTDOWN.
- SHUTDOWN: on `tick`, `d_boost` = max(`d_boost`−STEP, 0). When the value is 0 -> IDLE. `enable`=1 -> RAMP, continuing from the current `d_boost`. Targets are still accepted.
- FAULT: entered from any state when `fault`=1. `d_boost` is forced to 0 on the same edge, with no wait for a tick. The target register is cleared to 0. Exit to IDLE only when `fault`=0 and `enable`=0 in the same cycle.
- Priority on any edge: `rst` > `ce`=0 (hold) > `fault` > `enable` transitions > tick step > target compare.
- A tick and a target transfer in the same cycle: the step uses the old target, and the new target takes effect from the next cycle.

## Timing
- `clk_int` rising edge to `d_boost` update: 3 `clk` cycles (2 synchronizer stages plus 1 edge register/update), given `ce`=1.
- `fault` asserted to `d_boost`=0 and `state`=FAULT: 1 cycle.
- `enable` rising to `state`=RAMP: 1 cycle. The first duty change occurs on the next tick.
- `at_target` and `fault_latched` are registered, aligned with `state`.
- Full-scale ramp from 0 to 900 with STEP=4: 225 ticks (13.5 ms at 60 µs per tick).

## Test plan
- Soft start: `enable`=1, target 100, ticks every 60 µs -> `d_boost` goes 4, 8, …, 100 after 25 ticks. HOLD is entered with `at_target`=1.
- Clamp and non-multiple step: target 1023 -> captured as 900. Then retarget to 898 from HOLD at 900 -> RAMP, next tick gives 898, then HOLD.
- Shutdown: from HOLD at 20, drop `enable` -> SHUTDOWN. Ticks give 16, 12, 8, 4, 0, then IDLE. Re-asserting `enable` at 8 -> RAMP resumes from 8.
- Fault mid-ramp: at `d_boost`=52 assert `fault` -> next cycle `d_boost`=0, `state`=4, `tgt_ready`=0. Dropping `fault` with `enable`=1 stays in FAULT. Dropping `enable` -> IDLE.
- Simultaneous events: tick and target transfer in the same cycle -> step toward the old target. Then `ce`=0 across a tick -> no change; that tick is lost, with no later catch-up.
- Reset mid-ramp: `rst` pulse at `d_boost`=300 -> next cycle `d_boost`=0, IDLE, target 0, `at_target`=0.
